// File: rtl/bus_key_sequencer.sv
// Bus-snooping key sequencer: matches a sequence of address nibbles on window reads,
// then serves LFSR keystream bits until relock, stream exhaustion, or failure lockout.
module bus_key_sequencer #(
    parameter int                       ADDR_W     = 14,
    parameter logic [ADDR_W-1:0]        WIN_MASK   = 14'h3000,
    parameter logic [ADDR_W-1:0]        WIN_MATCH  = 14'h1000,
    parameter int                       NIB_LSB    = 4,
    parameter int                       NIB_W      = 4,
    parameter int                       SEQ_LEN    = 4,
    parameter logic [SEQ_LEN*NIB_W-1:0] SEQ_KEY    = 16'h29A5,
    parameter logic [NIB_W-1:0]         RELOCK_NIB = 4'hF,
    parameter int                       LFSR_W     = 6,
    parameter logic [LFSR_W-1:0]        LFSR_TAPS  = 6'h30,
    parameter logic [LFSR_W-1:0]        LFSR_SEED  = 6'h2B,
    parameter int                       STREAM_LEN = 8,
    parameter int                       MAX_FAIL   = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             bus_strobe,
    input  logic                             bus_cs_n,
    input  logic                             bus_rd,
    input  logic [ADDR_W-1:0]                bus_addr,
    output logic                             key_data,
    output logic                             key_oe,
    output logic                             unlocked,
    output logic                             locked_out,
    output logic [$clog2(SEQ_LEN+1)-1:0]     seq_pos
);

    localparam int SEQ_W     = $clog2(SEQ_LEN + 1);
    localparam int KEY_DEPTH = 1 << SEQ_W;
    localparam int FAIL_W    = (MAX_FAIL < 1) ? 1 : $clog2(MAX_FAIL + 1);
    localparam int BIT_W     = (STREAM_LEN < 1) ? 1 : $clog2(STREAM_LEN + 1);

    localparam logic [SEQ_W-1:0]  SEQ_LAST  = SEQ_W'(SEQ_LEN - 1);
    localparam logic [FAIL_W-1:0] FAIL_LIM  = FAIL_W'(MAX_FAIL);
    localparam logic [FAIL_W-1:0] FAIL_SAT  = '1;
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'((STREAM_LEN < 1) ? 0 : STREAM_LEN - 1);

    typedef enum logic [1:0] {
        ST_LOCKED   = 2'd0,
        ST_UNLOCKED = 2'd1,
        ST_LOCKOUT  = 2'd2
    } state_t;

    state_t              state;
    logic [SEQ_W-1:0]    pos_q;
    logic [FAIL_W-1:0]   fail_q;
    logic [BIT_W-1:0]    bit_q;
    logic [LFSR_W-1:0]   lfsr_q;

    logic                access;
    logic [NIB_W-1:0]    nib;
    logic [NIB_W-1:0]    key_arr [KEY_DEPTH];
    logic                key_match;
    logic                key_first;
    logic                relock;
    logic [FAIL_W-1:0]   fail_inc;
    logic [LFSR_W-1:0]   lfsr_next;

    // Table padded to a power of two so seq_pos indexes it without width games.
    for (genvar i = 0; i < KEY_DEPTH; i++) begin : g_key
        if (i < SEQ_LEN) begin : g_used
            assign key_arr[i] = SEQ_KEY[i*NIB_W +: NIB_W];
        end else begin : g_pad
            assign key_arr[i] = '0;
        end
    end

    assign access    = bus_strobe & ~bus_cs_n & bus_rd & ((bus_addr & WIN_MASK) == WIN_MATCH);
    assign nib       = bus_addr[NIB_LSB +: NIB_W];
    assign key_match = (nib == key_arr[pos_q]);
    assign key_first = (nib == key_arr[0]);
    assign relock    = (nib == RELOCK_NIB);
    assign fail_inc  = (fail_q == FAIL_SAT) ? fail_q : fail_q + FAIL_W'(1);
    assign lfsr_next = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & LFSR_TAPS)};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_LOCKED;
            pos_q  <= '0;
            fail_q <= '0;
            bit_q  <= '0;
            lfsr_q <= LFSR_SEED;
        end else if (access) begin
            case (state)
                ST_LOCKED: begin
                    if (key_match) begin
                        if (pos_q == SEQ_LAST) begin
                            state  <= ST_UNLOCKED;
                            pos_q  <= '0;
                            lfsr_q <= LFSR_SEED;
                            bit_q  <= '0;
                            fail_q <= '0;
                        end else begin
                            pos_q <= pos_q + SEQ_W'(1);
                        end
                    end else begin
                        // A mismatching nibble may itself be the start of a fresh attempt.
                        pos_q  <= key_first ? SEQ_W'(1) : '0;
                        fail_q <= fail_inc;
                        if ((MAX_FAIL != 0) && (fail_inc == FAIL_LIM)) begin
                            state <= ST_LOCKOUT;
                        end
                    end
                end
                ST_UNLOCKED: begin
                    if (relock) begin
                        state <= ST_LOCKED;
                        pos_q <= '0;
                    end else begin
                        lfsr_q <= lfsr_next;
                        if (STREAM_LEN != 0) begin
                            bit_q <= bit_q + BIT_W'(1);
                            if (bit_q == BIT_LAST) begin
                                state <= ST_LOCKED;
                                pos_q <= '0;
                            end
                        end
                    end
                end
                ST_LOCKOUT: begin
                    state <= ST_LOCKOUT;
                end
                default: begin
                    state <= ST_LOCKED;
                end
            endcase
        end
    end

    // Outputs are forced low while rst is held, even before the reset edge lands.
    assign key_oe     = ~rst & access & (state == ST_UNLOCKED) & ~relock;
    assign key_data   = key_oe & lfsr_q[LFSR_W-1];
    assign unlocked   = ~rst & (state == ST_UNLOCKED);
    assign locked_out = ~rst & (state == ST_LOCKOUT);
    assign seq_pos    = rst ? '0 : pos_q;

endmodule

// File: tb/tb_bus_key_sequencer.sv
// Directed bench for bus_key_sequencer: a behavioural model checked every cycle,
// plus literal expectations taken from hand-worked sequences.
module tb_bus_key_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        bus_strobe = 1'b0;
    logic        bus_cs_n = 1'b1;
    logic        bus_rd = 1'b0;
    logic [13:0] bus_addr = '0;
    logic        key_data;
    logic        key_oe;
    logic        unlocked;
    logic        locked_out;
    logic [2:0]  seq_pos;

    int n_vec = 0;
    int n_bad = 0;
    bit run = 1'b0;

    bus_key_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .bus_strobe (bus_strobe),
        .bus_cs_n   (bus_cs_n),
        .bus_rd     (bus_rd),
        .bus_addr   (bus_addr),
        .key_data   (key_data),
        .key_oe     (key_oe),
        .unlocked   (unlocked),
        .locked_out (locked_out),
        .seq_pos    (seq_pos)
    );

    always #5 clk = ~clk;

    // Model: mode 0 = locked, 1 = unlocked, 2 = lockout.
    int key_tab [4] = '{5, 10, 9, 2};
    int m_mode = 0;
    int m_pos  = 0;
    int m_fail = 0;
    int m_bits = 0;
    int m_lfsr = 'h2B;

    function automatic bit cur_access();
        return bus_strobe && !bus_cs_n && bus_rd && ((int'(bus_addr) / 'h1000) % 4 == 1);
    endfunction

    function automatic int cur_nib();
        return (int'(bus_addr) / 16) % 16;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_pos = 0; m_fail = 0; m_bits = 0; m_lfsr = 'h2B;
        end else if (cur_access()) begin
            if (m_mode == 0) begin
                if (cur_nib() == key_tab[m_pos]) begin
                    if (m_pos == 3) begin
                        m_mode = 1; m_pos = 0; m_lfsr = 'h2B; m_bits = 0; m_fail = 0;
                    end else begin
                        m_pos = m_pos + 1;
                    end
                end else begin
                    m_pos = (cur_nib() == key_tab[0]) ? 1 : 0;
                    if (m_fail < 3) m_fail = m_fail + 1;
                    if (m_fail == 3) m_mode = 2;
                end
            end else if (m_mode == 1) begin
                if (cur_nib() == 15) begin
                    m_mode = 0; m_pos = 0;
                end else begin
                    // Feedback is the parity of bits 5 and 4 (taps 0x30).
                    m_lfsr = ((m_lfsr * 2) % 64) + (((m_lfsr / 32) + (m_lfsr / 16)) % 2);
                    m_bits = m_bits + 1;
                    if (m_bits == 8) begin
                        m_mode = 0; m_pos = 0;
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (run) begin
            logic e_oe;
            e_oe = !rst && cur_access() && m_mode == 1 && cur_nib() != 15;
            chk("m_key_oe", 8'(key_oe), 8'(e_oe));
            chk("m_key_data", 8'(key_data), e_oe ? 8'((m_lfsr / 32) % 2) : 8'd0);
            chk("m_unlocked", 8'(unlocked), 8'(!rst && m_mode == 1));
            chk("m_locked_out", 8'(locked_out), 8'(!rst && m_mode == 2));
            chk("m_seq_pos", 8'(seq_pos), rst ? 8'd0 : 8'(m_pos));
        end
    end

    // Present one bus cycle; returns at the following negedge with it still driven.
    task automatic acc(input logic [13:0] a, input logic r = 1'b1, input logic c = 1'b0);
        @(posedge clk);
        #1;
        bus_strobe = 1'b1; bus_cs_n = c; bus_rd = r; bus_addr = a;
        @(negedge clk);
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bus_strobe = 1'b0; bus_cs_n = 1'b1; bus_rd = 1'b0; bus_addr = '0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; bus_strobe = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic unlock_seq();
        acc(14'h1050); acc(14'h10A0); acc(14'h1090); acc(14'h1020);
        idle();
    endtask

    initial begin
        @(posedge clk);
        run = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {3'b0, key_data, key_oe, unlocked, locked_out, 1'b0}, 8'd0);
        chk("rst_seq_pos", 8'(seq_pos), 8'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_outputs", {4'b0, key_data, key_oe, unlocked, locked_out}, 8'd0);

        // Unlock with the default key 5, A, 9, 2.
        acc(14'h1050); chk("u0_pos", 8'(seq_pos), 8'd0); chk("u0_oe", 8'(key_oe), 8'd0);
        acc(14'h10A0); chk("u1_pos", 8'(seq_pos), 8'd1); chk("u1_oe", 8'(key_oe), 8'd0);
        acc(14'h1090); chk("u2_pos", 8'(seq_pos), 8'd2); chk("u2_oe", 8'(key_oe), 8'd0);
        acc(14'h1020); chk("u3_pos", 8'(seq_pos), 8'd3); chk("u3_oe", 8'(key_oe), 8'd0);
        idle();        chk("u_unlocked", 8'(unlocked), 8'd1);

        // Keystream from seed 0x2B: 1, 0, 1.
        acc(14'h1000); chk("ks0_oe", 8'(key_oe), 8'd1); chk("ks0_data", 8'(key_data), 8'd1);
        acc(14'h1000); chk("ks1_oe", 8'(key_oe), 8'd1); chk("ks1_data", 8'(key_data), 8'd0);
        acc(14'h1000); chk("ks2_oe", 8'(key_oe), 8'd1); chk("ks2_data", 8'(key_data), 8'd1);
        for (int i = 3; i < 8; i++) begin
            acc(14'h1000); chk("ks_oe", 8'(key_oe), 8'd1);
        end
        idle();        chk("stream_end_unlocked", 8'(unlocked), 8'd0);
        acc(14'h1000); chk("ninth_oe", 8'(key_oe), 8'd0); chk("ninth_pos", 8'(seq_pos), 8'd0);
        do_reset();

        // Restart on a mismatch that equals key[0].
        acc(14'h1050); acc(14'h10A0);
        acc(14'h1050); chk("rs_pos_a", 8'(seq_pos), 8'd2);
        acc(14'h10A0); chk("rs_pos_b", 8'(seq_pos), 8'd1);
        acc(14'h1090); chk("rs_pos_c", 8'(seq_pos), 8'd2);
        acc(14'h1020); chk("rs_pos_d", 8'(seq_pos), 8'd3);
        idle();        chk("rs_unlocked", 8'(unlocked), 8'd1);

        // Non-accesses while unlocked leave the stream untouched.
        acc(14'h1000, 1'b0, 1'b0); chk("wr_oe", 8'(key_oe), 8'd0);
        acc(14'h1000, 1'b1, 1'b1); chk("cs_oe", 8'(key_oe), 8'd0);
        acc(14'h3050);             chk("win_oe", 8'(key_oe), 8'd0);
        idle();                    chk("na_unlocked", 8'(unlocked), 8'd1);
        acc(14'h1000); chk("na_first_data", 8'(key_data), 8'd1);
        acc(14'h10F0); chk("relock_oe", 8'(key_oe), 8'd0);
        idle();        chk("relock_unlocked", 8'(unlocked), 8'd0);
        chk("relock_pos", 8'(seq_pos), 8'd0);

        // fail_cnt was cleared on unlock, so lockout needs three fresh mismatches.
        acc(14'h1000); acc(14'h1000);
        idle();        chk("two_fail_lo", 8'(locked_out), 8'd0);
        acc(14'h1000);
        idle();        chk("three_fail_lo", 8'(locked_out), 8'd1);
        acc(14'h1050); acc(14'h10A0); chk("lo_pos", 8'(seq_pos), 8'd0);
        acc(14'h1090); acc(14'h1020);
        acc(14'h1000); chk("lo_oe", 8'(key_oe), 8'd0);
        idle();        chk("lo_unlocked", 8'(unlocked), 8'd0);
        chk("lo_held", 8'(locked_out), 8'd1);
        do_reset();
        chk("lo_rst_outputs", {4'b0, key_data, key_oe, unlocked, locked_out}, 8'd0);

        // Reset in the middle of a stream.
        unlock_seq();
        acc(14'h1000); acc(14'h1000);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_oe", 8'(key_oe), 8'd0);
        chk("mid_rst_unlocked", 8'(unlocked), 8'd0);
        @(posedge clk);
        #1 rst = 1'b0; bus_strobe = 1'b0;
        @(negedge clk);
        chk("after_rst_unlocked", 8'(unlocked), 8'd0);
        chk("after_rst_pos", 8'(seq_pos), 8'd0);
        unlock_seq();
        acc(14'h1000); chk("re_first_data", 8'(key_data), 8'd1);
        idle();
        idle();

        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
